mad_divider: RTL and testbench

MAD_DIVIDER -- requirements
Module: mad_divider

---
 rtl/mad_divider.sv | 100 ++++++++++
 tb/tb_mad_divider.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mad_divider.sv
// mad_divider: inverts R = A*B + C by computing (R - C) / B and (R - C) mod B
// with a restoring divider that retires one quotient bit per cycle.
module mad_divider #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [2*N-1:0] data_in,
    input  logic [N-1:0]   B,
    input  logic [N-1:0]   C,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           busy,
    output logic           done,
    output logic           err_div0,
    output logic           err_uflow
);
    localparam int CW = $clog2(2*N);
    typedef enum logic [1:0] {IDLE, SUB, DIV, DONE} state_t;
    state_t         state_q;
    logic [2*N-1:0] r_q, sh_q, quot_q;
    logic [N-1:0]   b_q, c_q, rmd_q;
    logic [N:0]     rem_q;
    logic [CW-1:0]  cnt_q;
    logic           done_q, div0_q, uflow_q;
    logic [2*N-1:0] diff_d;
    logic [N:0]     shifted_d, trial_d;
    logic           ge_d;
    assign diff_d    = r_q - {{N{1'b0}}, c_q};
    assign shifted_d = {rem_q[N-1:0], sh_q[2*N-1]};
    assign ge_d      = shifted_d >= {1'b0, b_q};
    assign trial_d   = ge_d ? shifted_d - {1'b0, b_q} : shifted_d;
    assign quotient  = quot_q;
    assign remainder = rmd_q;
    assign busy      = state_q != IDLE;
    assign done      = done_q;
    assign err_div0  = div0_q;
    assign err_uflow = uflow_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            r_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            sh_q    <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rmd_q   <= '0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
            uflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    r_q     <= data_in;
                    b_q     <= B;
                    c_q     <= C;
                    div0_q  <= 1'b0;
                    uflow_q <= 1'b0;
                    state_q <= SUB;
                end
                SUB: if (b_q == '0) begin
                    quot_q  <= '1;
                    rmd_q   <= '0;
                    div0_q  <= 1'b1;
                    state_q <= DONE;
                end else if (r_q < {{N{1'b0}}, c_q}) begin
                    quot_q  <= '0;
                    rmd_q   <= '0;
                    uflow_q <= 1'b1;
                    state_q <= DONE;
                end else begin
                    sh_q    <= diff_d;
                    rem_q   <= '0;
                    cnt_q   <= CW'(2*N-1);
                    state_q <= DIV;
                end
                DIV: begin
                    // dividend bits leave at the top while quotient bits enter at the bottom
                    sh_q  <= {sh_q[2*N-2:0], ge_d};
                    rem_q <= trial_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        quot_q  <= {sh_q[2*N-2:0], ge_d};
                        rmd_q   <= trial_d[N-1:0];
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mad_divider.sv
// tb_mad_divider: directed and random operations against an arithmetic
// reference model, checking results, flags, latency and done pulse width.
module tb_mad_divider;
    localparam int N = 8;
    logic           clk = 1'b0;
    logic           reset, start;
    logic [2*N-1:0] data_in;
    logic [N-1:0]   b, c;
    logic [2*N-1:0] quotient;
    logic [N-1:0]   remainder;
    logic           busy, done, err_div0, err_uflow;
    int checks = 0;
    int errors = 0;

    mad_divider #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in), .B(b), .C(c),
        .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
        .err_div0(err_div0), .err_uflow(err_uflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
    task automatic run_op(input logic [2*N-1:0] r, input logic [N-1:0] bv, input logic [N-1:0] cv);
        int d, eq, er, el, k;
        logic e0, eu;
        d  = int'(r) - int'(cv);
        e0 = bv == 0;
        eu = !e0 && d < 0;
        eq = e0 ? 'hFFFF : eu ? 0 : d / int'(bv);
        er = (e0 || eu) ? 0 : d % int'(bv);
        el = (e0 || eu) ? 2 : 2*N + 2;
        data_in = r;
        b = bv;
        c = cv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        data_in = 16'($urandom);
        b = 8'($urandom);
        c = 8'($urandom);
        chk("busy_after_start", busy, 1);
        chk("done_pulse_low", done, 0);
        k = 1;
        while (!done && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("latency", k - 1, el);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("err_div0", err_div0, e0);
        chk("err_uflow", err_uflow, eu);
        chk("busy_at_done", busy, 0);
    endtask

    initial begin
        int pulses;
        logic [2*N-1:0] rr, q1;
        logic [N-1:0] bb, cc, r1;
        reset = 1'b1;
        start = 1'b1;
        data_in = 96;
        b = 7;
        c = 5;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_errs", {err_div0, err_uflow}, 0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        run_op(96, 7, 5);
        run_op(100, 7, 5);
        run_op(16'hFFFF, 1, 0);
        run_op(50, 0, 3);
        run_op(3, 4, 5);
        run_op(3, 0, 5);
        run_op(16'hFFFF, 8'hFF, 0);
        run_op(5, 9, 5);
        // second start mid-operation must be dropped
        data_in = 100;
        b = 7;
        c = 5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        data_in = 200;
        b = 3;
        c = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        q1 = '0;
        r1 = '0;
        repeat (40) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                q1 = quotient;
                r1 = remainder;
            end
        end
        chk("busy_start_pulses", pulses, 1);
        chk("busy_start_quotient", q1, 13);
        chk("busy_start_remainder", r1, 4);
        // reset during DIV abandons the operation
        data_in = 96;
        b = 7;
        c = 5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_quotient", quotient, 0);
        chk("mid_rst_remainder", remainder, 0);
        chk("mid_rst_errs", {err_div0, err_uflow}, 0);
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("mid_rst_no_done", pulses, 0);
        run_op(96, 7, 5);
        for (int i = 0; i < 30; i++) begin
            cc = 8'($urandom);
            bb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            rr = ($urandom_range(0, 7) == 0 && cc > 0) ? 16'($urandom_range(0, int'(cc) - 1)) : 16'($urandom);
            run_op(rr, bb, cc);
        end
        @(negedge clk);
        chk("final_done_low", done, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
